// File: rtl/updn_seq_ctrl.sv
// updn_seq_ctrl: command-driven up/down counter sequencer.
// A command is accepted in IDLE. The counter then steps one count per cycle
// toward the latched target, dwells HOLD_CYCLES cycles at the target, and
// pulses done for one cycle.
// Optional build macro UDSEQ_SHORTEST_PATH_EN: the direction is picked by the
// smaller modular distance, so RUN may wrap. Ties go up.
// Without the macro, the counter runs up when target > count, otherwise down,
// and it never wraps.
//
// Handshake: a command transfers on a rising edge where cmd_valid=1 and
// cmd_ready=1. cmd_ready depends only on state and is high only in IDLE.
// cmd_valid seen in any other state is dropped, and nothing is queued.
module updn_seq_ctrl #(
  parameter int WIDTH       = 3,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             up_down,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_target;
  logic             r_dir;
  logic [7:0]       r_hold;

  logic             w_dir;
  logic             w_at_target;
  logic [WIDTH-1:0] w_d_up;
  logic [WIDTH-1:0] w_d_dn;

  // Direction a command would latch if it were accepted this cycle.
  always_comb begin
    w_d_up = cmd_target - r_count;
    w_d_dn = r_count - cmd_target;
`ifdef UDSEQ_SHORTEST_PATH_EN
    w_dir  = (w_d_up <= w_d_dn) ? 1'b0 : 1'b1;
`else
    w_dir  = (cmd_target > r_count) ? 1'b0 : 1'b1;
`endif
  end

  assign w_at_target = (r_count == r_target);

  // Sequencer state, counter, latched command and dwell counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_target <= '0;
      r_dir    <= 1'b0;
      r_hold   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_target <= cmd_target;
            r_dir    <= w_dir;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (w_at_target) begin
            r_hold  <= 8'(HOLD_CYCLES);
            r_state <= S_HOLD;
          end else if (r_dir) begin
            r_count <= r_count - WIDTH'(1);
          end else begin
            r_count <= r_count + WIDTH'(1);
          end
        end
        S_HOLD: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (r_hold <= 8'd1) begin
            r_state <= S_DONE;
          end else begin
            r_hold <= r_hold - 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state. cnt_en drops in an abort cycle
  // because no step follows that edge.
  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    cnt_en    = (r_state == S_RUN) && !w_at_target && !abort;
    up_down   = r_dir;
    count     = r_count;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_updn_seq_ctrl.sv
// Testbench for updn_seq_ctrl: directed scenarios plus randomized commands.
// Every command is expanded into its expected per-cycle output trace.
module tb_updn_seq_ctrl;

  localparam int W = 3;
  localparam int H = 2;
  localparam int M = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_target;
  logic         abort;
  logic [W-1:0] count;
  logic         up_down;
  logic         cnt_en;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  int n_vec  = 0;
  int n_fail = 0;
  int m_count = 0;

  // Expected-value scoreboard for the count output.
  logic [W-1:0] exp_q[$];

  updn_seq_ctrl #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .abort      (abort),
    .count      (count),
    .up_down    (up_down),
    .cnt_en     (cnt_en),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Outputs expected while idle.
  task automatic check_idle();
    check_eq("idle_count", int'(count), m_count);
    check_eq("idle_cnt_en", int'(cnt_en), 0);
    check_eq("idle_busy", int'(busy), 0);
    check_eq("idle_done", int'(done), 0);
    check_eq("idle_ready", int'(cmd_ready), 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b0;
      cmd_valid = 1'b0;
      cmd_target = W'($urandom);
      abort = 1'($urandom_range(0, 1));
      #1;
      check_idle();
    end
  endtask

  // Issue one command and check the whole expected trace.
  // ab_k and rst_k give the cycle after accept in which abort or reset is
  // raised; 0 means never. An ab_k below 0 picks a random cycle.
  task automatic run_cmd(input int t, input int ab_k_in, input int rst_k, input int ab_acc);
    int c, dir, d, total, cur, ab_k, d_up, d_dn;
    bit en;
    c = m_count;
`ifdef UDSEQ_SHORTEST_PATH_EN
    d_up = (t - c) & M;
    d_dn = (c - t) & M;
    dir = (d_up <= d_dn) ? 0 : 1;
    d = (dir == 0) ? d_up : d_dn;
`else
    d_up = t - c;
    d_dn = c - t;
    dir = (t > c) ? 0 : 1;
    d = (dir == 0) ? d_up : d_dn;
`endif
    total = d + 2 + H;
    ab_k = (ab_k_in < 0) ? $urandom_range(1, total) : ab_k_in;
    // accept cycle
    @(negedge clk);
    reset = 1'b0;
    cmd_valid = 1'b1;
    cmd_target = W'(t);
    abort = 1'(ab_acc);
    #1;
    check_idle();
    for (int j = 1; j <= total; j++) begin
      @(negedge clk);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_target = W'($urandom);
      abort = (j == ab_k);
      reset = (j == rst_k);
      #1;
      if (j <= d) cur = (dir == 1) ? ((c - (j - 1)) & M) : ((c + (j - 1)) & M);
      else cur = t;
      en = (j <= d) && (j != ab_k);
      exp_q.push_back(W'(cur));
      check_eq("count", int'(count), int'(exp_q.pop_front()));
      check_eq("cnt_en", int'(cnt_en), int'(en));
      if (en) check_eq("up_down", int'(up_down), dir);
      check_eq("busy", int'(busy), 1);
      check_eq("done", int'(done), int'(j == total));
      check_eq("cmd_ready", int'(cmd_ready), 0);
      m_count = cur;
      if (j == rst_k) begin
        m_count = 0;
        break;
      end
      if (j == ab_k && j < total) break;
    end
  endtask

  // Main stimulus: reset, directed scenarios, then random commands.
  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_target = '0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    // reset wins over a command and an abort
    cmd_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    m_count = 0;
    idle_cycles(2);

    run_cmd(5, 0, 0, 0);   // up 1..5, hold, done
    idle_cycles(1);
    run_cmd(2, 0, 0, 0);   // down 4,3,2
    idle_cycles(1);
    run_cmd(1, 0, 0, 0);
    run_cmd(6, 0, 0, 0);   // 1 -> 6, direction depends on build
    idle_cycles(1);
    run_cmd(3, 0, 0, 0);
    run_cmd(3, 0, 0, 1);   // target equals count; abort with accept
    idle_cycles(1);
    run_cmd(0, 0, 0, 0);
    run_cmd(6, 3, 0, 0);   // abort part way through
    run_cmd(4, 0, 0, 0);   // accepted right after abort
    run_cmd(1, 0, 0, 0);
    run_cmd(4, 0, 5, 0);   // reset in HOLD at count 4
    idle_cycles(2);
    run_cmd(7, 0, 0, 0);
    run_cmd(2, H + 2 + 5, 0, 0); // abort in DONE is ignored (7 -> 2 is d=5)
    idle_cycles(1);

    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6) run_cmd($urandom_range(0, M), 0, 0, $urandom_range(0, 1));
      else if (sel < 9) run_cmd($urandom_range(0, M), -1, 0, 0);
      else run_cmd($urandom_range(0, M), 0, $urandom_range(1, 3), 0);
      idle_cycles($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/updn_seq_ctrl.md
UPDN_SEQ_CTRL -- requirements
Module: updn_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 3, counter width in bits.
REQ-002 Parameter HOLD_CYCLES, default 2, number of dwell cycles at the target before completion; legal range 1..255.
REQ-003 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accept; high only in IDLE.
REQ-007 cmd_target  input  WIDTH  target count; sampled on accept.
REQ-008 abort  input  1  terminates the active command.
REQ-009 count  output  WIDTH  current counter value, registered.
REQ-010 up_down  output  1  step direction (0 = up, 1 = down); meaningful only while cnt_en=1.
REQ-011 cnt_en  output  1  high in every cycle in which count steps at the next edge.
REQ-012 busy  output  1  high in RUN, HOLD and DONE.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN, HOLD and DONE.
REQ-015 Accept: an edge with cmd_valid=1 and cmd_ready=1 SHALL latch cmd_target and the direction, then move IDLE to RUN.
REQ-016 cmd_valid in any other state SHALL be ignored, with no queuing.
REQ-017 Default direction: up_down=0 if target>count, else 1; the direction is latched at accept and held until the command ends.
REQ-018 RUN with count!=target: cnt_en=1; count SHALL step by 1 per cycle in the latched direction, with modulo 2^WIDTH wrap (all-ones+1=0, 0-1=all-ones).
REQ-019 RUN with count==target: cnt_en=0, no step; the FSM SHALL go to HOLD and load the dwell counter with HOLD_CYCLES.
REQ-020 Latency: for distance d, count SHALL reach the target at edge d after the accept edge; HOLD is entered at edge d+1.
REQ-021 Target equal to count at accept: d=0; the FSM SHALL spend one RUN cycle, then HOLD.
REQ-022 HOLD: count SHALL be frozen for exactly HOLD_CYCLES cycles, then the FSM SHALL go to DONE.
REQ-023 DONE: done=1 and cmd_ready=0 for exactly one cycle, then IDLE.
REQ-024 abort=1 in RUN or HOLD: the FSM SHALL return to IDLE at the next edge, count retains its value, done is not asserted, and cnt_en=0 in that cycle.
REQ-025 abort in IDLE or DONE SHALL be ignored; a DONE pulse SHALL still complete.
REQ-026 abort and cmd_valid together in IDLE: the command SHALL be accepted.
REQ-027 count SHALL change only in RUN.

Reset
REQ-028 reset=1 at an edge SHALL force: state IDLE, count=0, up_down=0, cnt_en=0, busy=0, done=0, cmd_ready=1 from the next cycle.
REQ-029 Reset SHALL take priority over abort and cmd_valid.
REQ-030 Reset mid-command SHALL discard the latched target; no done is produced.

Configuration
REQ-031 Macro UDSEQ_SHORTEST_PATH_EN defined: the direction SHALL be the one with the smaller modular distance, d_up=(target-count) mod 2^WIDTH vs d_dn=(count-target) mod 2^WIDTH.
REQ-032 With UDSEQ_SHORTEST_PATH_EN defined, a tie SHALL select up (up_down=0); RUN may then wrap through 0/all-ones.
REQ-033 Macro UDSEQ_SHORTEST_PATH_EN undefined: the direction SHALL follow REQ-017, and RUN never wraps.

Verification
REQ-034 Reset, then target=5, HOLD_CYCLES=2 -> count 1,2,3,4,5 on edges 1-5 after accept, up_down=0, HOLD 2 cycles, done pulses once, cmd_ready back to 1.
REQ-035 From count=5, target=2 (macro undefined) -> up_down=1, count 4,3,2, then HOLD, then done.
REQ-036 From count=1, target=6 with UDSEQ_SHORTEST_PATH_EN -> up_down=1, count 0,7,6, done; without the macro -> up through 2..6.
REQ-037 Target equal to count (3) -> cnt_en never high, count stays 3, done at accept+1+HOLD_CYCLES+1.
REQ-038 abort at count=2 while running 0->6 -> IDLE next edge, count stays 2, no done; a new command is accepted next cycle.
REQ-039 reset in HOLD at count=4 -> count=0, state IDLE, done=0; cmd_valid while busy -> ignored, cmd_ready=0.
